// File: rtl/fpalu_pkg.sv
// Shared FP ALU definitions: FP29i/FP16 widths, biases, FP16 constants, the
// FP29i operand struct and the leading-zero counter used by the pack stage.
package fpalu_pkg;

    localparam int MAN_W        = 22;
    localparam int EXP_W        = 6;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int EXP_BIAS_IN  = 30;
    localparam int EXP_BIAS_OUT = 15;

    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp29i_t;

    // Returns MAN_W for an all-zero mantissa.
    function automatic logic [4:0] lzc(input logic [MAN_W-1:0] m);
        logic [4:0] n;
        n = 5'(MAN_W);
        for (int unsigned i = 0; i < MAN_W; i++) begin
            if (m[i]) n = 5'(MAN_W - 1 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp29i_to_fp16_pack_if.sv
// Handshake and data bundle between the FP ALU (master) and the FP16 pack stage (slave).
interface fp29i_to_fp16_pack_if
    import fpalu_pkg::*;
;
    logic             in_valid;
    logic             in_ready;
    logic             in_sgn;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_fp16;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_sgn, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_fp16, out_flags
    );

    modport slave (
        input  in_valid, in_sgn, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_fp16, out_flags
    );
endinterface

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even on a 10-bit FP16 fraction with guard/round/sticky.
module fp_rne_round
    import fpalu_pkg::*;
(
    input  logic [FP16_FRAC_W-1:0] frac_i,
    input  logic                   g,
    input  logic                   r,
    input  logic                   s,
    input  logic [7:0]             exp_i,
    output logic [FP16_FRAC_W-1:0] frac_o,
    output logic [7:0]             exp_o,
    output logic                   carry
);
    logic up;

    assign up = g & (r | s | frac_i[0]);
    assign {carry, frac_o} = {1'b0, frac_i} + {{FP16_FRAC_W{1'b0}}, up};
    // Fraction wrap means 1.111.. -> 10.000, or a denormal reaching the hidden bit.
    assign exp_o = exp_i + {7'b0, carry};
endmodule

// File: rtl/fp29i_to_fp16_pack.sv
// FP29i -> IEEE FP16 pack: 3-stage pipe (LZD, align, RNE round/pack) with valid/ready.
// Define FP16_PACK_SATURATE_EN to clamp overflow to max finite instead of infinity.
module fp29i_to_fp16_pack
    import fpalu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fp29i_to_fp16_pack_if.slave  bus
);
    localparam int EXP_ADJ = EXP_BIAS_IN - EXP_BIAS_OUT - 1;
`ifdef FP16_PACK_SATURATE_EN
    localparam logic [14:0] OVF_MAG = FP16_MAXF[14:0];
`else
    localparam logic [14:0] OVF_MAG = FP16_PINF[14:0];
`endif

    fp29i_t      op;
    logic        adv;
    logic [4:0]  lz_in;

    logic              s1_valid, s1_sgn, s1_zero;
    logic signed [7:0] s1_e;
    logic [4:0]        s1_lz;
    logic [MAN_W-1:0]  s1_man;

    logic [MAN_W-1:0]       norm;
    logic [7:0]             sh;
    logic [44:0]            wide;
    logic [7:0]             a_exp;
    logic [FP16_FRAC_W-1:0] a_frac;
    logic                   a_g, a_r, a_s;

    logic                   s2_valid, s2_sgn, s2_zero;
    logic [7:0]             s2_exp;
    logic [FP16_FRAC_W-1:0] s2_frac;
    logic                   s2_g, s2_r, s2_s;

    logic [FP16_FRAC_W-1:0] r_frac;
    logic [7:0]             r_exp;
    logic                   r_carry;
    logic                   inexact, denorm;
    logic [15:0]            p_fp;
    logic [2:0]             p_flags;

    assign op          = '{sgn: bus.in_sgn, exp: bus.in_exp, man: bus.in_man};
    assign adv         = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign lz_in       = lzc(op.man);

    // Align: normalize to 1.f, then denormals shift right by (1 - E) with a
    // 24-bit pad so nothing is lost before it is folded into sticky.
    always_comb begin
        norm  = s1_man << s1_lz;
        a_exp = '0;
        sh    = '0;
        if (s1_e > 8'sd0) a_exp = 8'(s1_e);
        else              sh    = 8'(8'sd1 - s1_e);
        wide = 45'({norm, 24'b0} >> sh);
        if (sh >= 8'd24) begin
            a_frac = '0;
            a_g    = 1'b0;
            a_r    = 1'b0;
            a_s    = |s1_man;
        end else begin
            a_frac = wide[44:35];
            a_g    = wide[34];
            a_r    = wide[33];
            a_s    = |wide[32:0];
        end
    end

    fp_rne_round u_round (
        .frac_i (s2_frac),
        .g      (s2_g),
        .r      (s2_r),
        .s      (s2_s),
        .exp_i  (s2_exp),
        .frac_o (r_frac),
        .exp_o  (r_exp),
        .carry  (r_carry)
    );

    always_comb begin
        inexact = s2_g | s2_r | s2_s;
        denorm  = (s2_exp == '0) & ~r_carry;
        p_fp    = {s2_sgn, r_exp[4:0], r_frac};
        p_flags = {1'b0, denorm & inexact, inexact};
        if (s2_zero) begin
            p_fp    = {s2_sgn, 15'h0};
            p_flags = '0;
        end else if (r_exp >= 8'd31) begin
            p_fp    = {s2_sgn, OVF_MAG};
            p_flags = 3'b101;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_fp16  <= '0;
            bus.out_flags <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_sgn   <= op.sgn;
            s1_zero  <= (op.man == '0);
            s1_lz    <= lz_in;
            s1_man   <= op.man;
            s1_e     <= $signed({2'b00, op.exp}) - $signed(8'(EXP_ADJ)) - $signed({3'b000, lz_in});

            s2_valid <= s1_valid;
            s2_sgn   <= s1_sgn;
            s2_zero  <= s1_zero;
            s2_exp   <= a_exp;
            s2_frac  <= a_frac;
            s2_g     <= a_g;
            s2_r     <= a_r;
            s2_s     <= a_s;

            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.out_fp16  <= p_fp;
                bus.out_flags <= p_flags;
            end
        end
    end
endmodule
